// File: rtl/tlb_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tlb_refill_ctrl
//
// Sv39 page-table walker for the prv664 TLBs. It takes a miss from the ITLB
// (requester 0) or the DTLB (requester 1) and walks the page table one level at
// a time. Only one walk is in flight, and each walk uses a single-outstanding
// memory read port. A walk ends in one of two ways:
//   - a TLB update strobe plus a success completion, or
//   - a page-fault completion (flagged as an access fault when the PTE fetch
//     itself returned an error).
//
// Optional feature macro: PRV664_PTW_AD_CHECK_EN
//   defined   : software-managed A/D. A leaf with A=0 faults. A DTLB leaf with
//               W=1 and D=0 also faults.
//   undefined : A/D bits pass through unchecked in upd_pte_o.
//
// Parameters
//   PADDR_WIDTH : width of the PTE fetch address
//   RR_INIT     : requester holding round-robin priority after reset
//                 (0 = ITLB, 1 = DTLB)
//
// Ports
//   clk_i, arst_i            clock, asynchronous active-high reset
//   flush_i                  sfence / satp change, kills the current walk
//   satp_ppn_i               root page-table PPN
//   reqN_valid_i/_vpn_i      miss request and missing VPN {vpn2,vpn1,vpn0}
//   reqN_ready_o             request accepted this cycle (IDLE only)
//   mem_req_valid_o/_ready_i/_addr_o   PTE read request channel
//   mem_rsp_valid_i/_data_i/_err_i     PTE read response channel
//   upd_*_o                  TLB update port (valid/we/side/level/vpn/ppn/pte)
//   done_*_o                 walk completion pulse with id and fault flags
// -----------------------------------------------------------------------------
module tlb_refill_ctrl #(
    parameter int PADDR_WIDTH = 56,
    parameter bit RR_INIT     = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic                   flush_i,
    input  logic [43:0]            satp_ppn_i,
    input  logic                   req0_valid_i,
    input  logic [26:0]            req0_vpn_i,
    output logic                   req0_ready_o,
    input  logic                   req1_valid_i,
    input  logic [26:0]            req1_vpn_i,
    output logic                   req1_ready_o,
    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic [PADDR_WIDTH-1:0] mem_req_addr_o,
    input  logic                   mem_rsp_valid_i,
    input  logic [63:0]            mem_rsp_data_i,
    input  logic                   mem_rsp_err_i,
    output logic                   upd_valid_o,
    output logic                   upd_we_o,
    output logic                   upd_sel_o,
    output logic [1:0]             upd_level_o,
    output logic [26:0]            upd_vpn_o,
    output logic [25:0]            upd_ppn2_o,
    output logic [8:0]             upd_ppn1_o,
    output logic [8:0]             upd_ppn0_o,
    output logic [7:0]             upd_pte_o,
    output logic                   done_valid_o,
    output logic                   done_id_o,
    output logic                   done_fault_o,
    output logic                   done_access_fault_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_UPDATE,
        S_FAULT
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_rr;
    logic        r_kill;
    logic        r_id;
    logic [26:0] r_vpn;
    logic [1:0]  r_level;
    // Holds the next-level table PPN during the walk, and the leaf PPN once
    // the walk reaches UPDATE.
    logic [43:0] r_ppn;
    logic [7:0]  r_flags;
    logic        r_access_fault;

    logic        w_grant_ok;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_both_valid;
    logic [8:0]  w_vpn_idx;
    logic [55:0] w_addr_full;

    logic        w_pte_v;
    logic        w_pte_r;
    logic        w_pte_w;
    logic        w_pte_x;
    logic        w_pte_leaf;
    logic [8:0]  w_pte_ppn1;
    logic [8:0]  w_pte_ppn0;
    logic        w_misaligned;
    logic        w_ad_fault;
    logic        w_rsp_fault;
    logic        w_rsp_take;
    logic        w_unused;

    // Reserved PTE bits and RSW are never looked at by the walker.
    assign w_unused = ^{mem_rsp_data_i[63:54], mem_rsp_data_i[9:8]};

    // Grant arbitration. Grants only happen in IDLE. When both requesters are
    // valid, the round-robin side wins.
    assign w_grant_ok   = (r_state == S_IDLE) && !flush_i && !arst_i;
    assign w_both_valid = req0_valid_i && req1_valid_i;
    assign w_grant0     = w_grant_ok && req0_valid_i && (!req1_valid_i || !r_rr);
    assign w_grant1     = w_grant_ok && req1_valid_i && (!req0_valid_i ||  r_rr);

    // PTE decode of the returning response.
    assign w_pte_v    = mem_rsp_data_i[0];
    assign w_pte_r    = mem_rsp_data_i[1];
    assign w_pte_w    = mem_rsp_data_i[2];
    assign w_pte_x    = mem_rsp_data_i[3];
    assign w_pte_leaf = w_pte_r || w_pte_x;
    assign w_pte_ppn1 = mem_rsp_data_i[27:19];
    assign w_pte_ppn0 = mem_rsp_data_i[18:10];

    // A superpage leaf must have its lower PPN fields clear.
    assign w_misaligned = ((r_level == 2'd2) && ((w_pte_ppn1 | w_pte_ppn0) != 9'd0)) ||
                          ((r_level == 2'd1) && (w_pte_ppn0 != 9'd0));

`ifdef PRV664_PTW_AD_CHECK_EN
    assign w_ad_fault = !mem_rsp_data_i[6] ||
                        (r_id && w_pte_w && !mem_rsp_data_i[7]);
`else
    assign w_ad_fault = 1'b0;
`endif

    assign w_rsp_fault = !w_pte_v ||
                         (!w_pte_r && w_pte_w) ||
                         (w_pte_leaf && (w_misaligned || w_ad_fault)) ||
                         (!w_pte_leaf && (r_level == 2'd0));

    // A response that belongs to a live, unflushed walk.
    assign w_rsp_take = (r_state == S_WAIT) && mem_rsp_valid_i && !r_kill && !flush_i;

    // VPN slice indexed by the current level, and the PTE address built from it.
    always_comb begin
        w_vpn_idx = r_vpn[8:0];
        case (r_level)
            2'd2:    w_vpn_idx = r_vpn[26:18];
            2'd1:    w_vpn_idx = r_vpn[17:9];
            default: w_vpn_idx = r_vpn[8:0];
        endcase
    end

    assign w_addr_full = {r_ppn, w_vpn_idx, 3'b000};

    // State register.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant0 || w_grant1) begin
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                // A request that was accepted together with a flush still
                // gets a response, so it must be drained in WAIT.
                if (mem_req_ready_i) begin
                    w_next_state = S_WAIT;
                end else if (flush_i) begin
                    w_next_state = S_IDLE;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid_i) begin
                    if (r_kill || flush_i) begin
                        w_next_state = S_IDLE;
                    end else if (mem_rsp_err_i || w_rsp_fault) begin
                        w_next_state = S_FAULT;
                    end else if (w_pte_leaf) begin
                        w_next_state = S_UPDATE;
                    end else begin
                        w_next_state = S_REQ;
                    end
                end
            end
            S_UPDATE: w_next_state = S_IDLE;
            S_FAULT:  w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Walk context: requester, VPN, level, PPN, leaf flags, kill flag.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_rr           <= RR_INIT;
            r_kill         <= 1'b0;
            r_id           <= 1'b0;
            r_vpn          <= 27'd0;
            r_level        <= 2'd0;
            r_ppn          <= 44'd0;
            r_flags        <= 8'd0;
            r_access_fault <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_id           <= w_grant1;
                        r_vpn          <= w_grant1 ? req1_vpn_i : req0_vpn_i;
                        r_level        <= 2'd2;
                        r_ppn          <= satp_ppn_i;
                        r_access_fault <= 1'b0;
                        r_kill         <= 1'b0;
                        if (w_both_valid) begin
                            r_rr <= w_grant0;
                        end
                    end
                end
                S_REQ: begin
                    if (flush_i && mem_req_ready_i) begin
                        r_kill <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (flush_i) begin
                        r_kill <= 1'b1;
                    end
                    if (w_rsp_take) begin
                        if (mem_rsp_err_i) begin
                            r_access_fault <= 1'b1;
                        end else if (!w_rsp_fault) begin
                            r_ppn   <= mem_rsp_data_i[53:10];
                            r_flags <= mem_rsp_data_i[7:0];
                            if (!w_pte_leaf) begin
                                r_level <= r_level - 2'd1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs. Every field is zero unless its strobe is active. A flush in
    // UPDATE or FAULT swallows that completion.
    always_comb begin
        req0_ready_o        = w_grant0;
        req1_ready_o        = w_grant1;
        mem_req_valid_o     = 1'b0;
        mem_req_addr_o      = '0;
        upd_valid_o         = 1'b0;
        upd_we_o            = 1'b0;
        upd_sel_o           = 1'b0;
        upd_level_o         = 2'd0;
        upd_vpn_o           = 27'd0;
        upd_ppn2_o          = 26'd0;
        upd_ppn1_o          = 9'd0;
        upd_ppn0_o          = 9'd0;
        upd_pte_o           = 8'd0;
        done_valid_o        = 1'b0;
        done_id_o           = 1'b0;
        done_fault_o        = 1'b0;
        done_access_fault_o = 1'b0;
        case (r_state)
            S_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = PADDR_WIDTH'(w_addr_full);
            end
            S_UPDATE: begin
                if (!flush_i) begin
                    upd_valid_o  = 1'b1;
                    upd_we_o     = 1'b1;
                    upd_sel_o    = r_id;
                    upd_level_o  = r_level;
                    upd_vpn_o    = r_vpn;
                    upd_ppn2_o   = r_ppn[43:18];
                    upd_ppn1_o   = r_ppn[17:9];
                    upd_ppn0_o   = r_ppn[8:0];
                    upd_pte_o    = r_flags;
                    done_valid_o = 1'b1;
                    done_id_o    = r_id;
                end
            end
            S_FAULT: begin
                if (!flush_i) begin
                    done_valid_o        = 1'b1;
                    done_id_o           = r_id;
                    done_fault_o        = 1'b1;
                    done_access_fault_o = r_access_fault;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tlb_refill_ctrl
//
// Directed testbench for tlb_refill_ctrl. Each scenario is a test_* task. The
// tasks share the same phase: each one starts and ends 2 time units after a
// rising clock edge. A negedge monitor records the strobes on the memory
// request, update and done ports so that the scenarios can compare counts and
// fields against hand-computed values.
// -----------------------------------------------------------------------------
module tb_tlb_refill_ctrl;

    logic        clk_i = 1'b0;
    logic        arst_i;
    logic        flush_i;
    logic [43:0] satp_ppn_i;
    logic        req0_valid_i;
    logic [26:0] req0_vpn_i;
    logic        req0_ready_o;
    logic        req1_valid_i;
    logic [26:0] req1_vpn_i;
    logic        req1_ready_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [55:0] mem_req_addr_o;
    logic        mem_rsp_valid_i;
    logic [63:0] mem_rsp_data_i;
    logic        mem_rsp_err_i;
    logic        upd_valid_o;
    logic        upd_we_o;
    logic        upd_sel_o;
    logic [1:0]  upd_level_o;
    logic [26:0] upd_vpn_o;
    logic [25:0] upd_ppn2_o;
    logic [8:0]  upd_ppn1_o;
    logic [8:0]  upd_ppn0_o;
    logic [7:0]  upd_pte_o;
    logic        done_valid_o;
    logic        done_id_o;
    logic        done_fault_o;
    logic        done_access_fault_o;

    int checks = 0;
    int errors = 0;

    int          nReads = 0;
    int          nUpd   = 0;
    int          nDone  = 0;
    logic        capWe     = 1'b0;
    logic        capSel    = 1'b0;
    logic [1:0]  capLevel  = 2'd0;
    logic [26:0] capVpn    = 27'd0;
    logic [25:0] capPpn2   = 26'd0;
    logic [8:0]  capPpn1   = 9'd0;
    logic [8:0]  capPpn0   = 9'd0;
    logic [7:0]  capPte    = 8'd0;
    logic        capId     = 1'b0;
    logic        capFault  = 1'b0;
    logic        capAccess = 1'b0;

    always #5 clk_i = ~clk_i;

    tlb_refill_ctrl #(
        .PADDR_WIDTH (56),
        .RR_INIT     (1'b0)
    ) dut (
        .clk_i               (clk_i),
        .arst_i              (arst_i),
        .flush_i             (flush_i),
        .satp_ppn_i          (satp_ppn_i),
        .req0_valid_i        (req0_valid_i),
        .req0_vpn_i          (req0_vpn_i),
        .req0_ready_o        (req0_ready_o),
        .req1_valid_i        (req1_valid_i),
        .req1_vpn_i          (req1_vpn_i),
        .req1_ready_o        (req1_ready_o),
        .mem_req_valid_o     (mem_req_valid_o),
        .mem_req_ready_i     (mem_req_ready_i),
        .mem_req_addr_o      (mem_req_addr_o),
        .mem_rsp_valid_i     (mem_rsp_valid_i),
        .mem_rsp_data_i      (mem_rsp_data_i),
        .mem_rsp_err_i       (mem_rsp_err_i),
        .upd_valid_o         (upd_valid_o),
        .upd_we_o            (upd_we_o),
        .upd_sel_o           (upd_sel_o),
        .upd_level_o         (upd_level_o),
        .upd_vpn_o           (upd_vpn_o),
        .upd_ppn2_o          (upd_ppn2_o),
        .upd_ppn1_o          (upd_ppn1_o),
        .upd_ppn0_o          (upd_ppn0_o),
        .upd_pte_o           (upd_pte_o),
        .done_valid_o        (done_valid_o),
        .done_id_o           (done_id_o),
        .done_fault_o        (done_fault_o),
        .done_access_fault_o (done_access_fault_o)
    );

    // Records handshakes and strobes once per cycle, away from the active edge.
    always @(negedge clk_i) begin
        if (mem_req_valid_o && mem_req_ready_i) begin
            nReads <= nReads + 1;
        end
        if (upd_valid_o) begin
            nUpd     <= nUpd + 1;
            capWe    <= upd_we_o;
            capSel   <= upd_sel_o;
            capLevel <= upd_level_o;
            capVpn   <= upd_vpn_o;
            capPpn2  <= upd_ppn2_o;
            capPpn1  <= upd_ppn1_o;
            capPpn0  <= upd_ppn0_o;
            capPte   <= upd_pte_o;
        end
        if (done_valid_o) begin
            nDone     <= nDone + 1;
            capId     <= done_id_o;
            capFault  <= done_fault_o;
            capAccess <= done_access_fault_o;
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    // Raises one request for a cycle and reports the ready seen in that cycle.
    task automatic issue_req(input logic side, input logic [26:0] vpn, output logic rdy);
        if (side) begin
            req1_valid_i = 1'b1;
            req1_vpn_i   = vpn;
        end else begin
            req0_valid_i = 1'b1;
            req0_vpn_i   = vpn;
        end
        #1;
        rdy = side ? req1_ready_o : req0_ready_o;
        @(posedge clk_i);
        #1;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        #1;
    endtask

    // Waits (bounded) for a PTE read and accepts it. Then returns the given
    // data. A timeout is reported with addr forced to zero.
    task automatic serve_read(input logic [63:0] data, input logic err,
                              output logic [55:0] addr, output logic timedOut);
        timedOut = 1'b1;
        addr     = '0;
        for (int i = 0; i < 16; i++) begin
            if (mem_req_valid_o) begin
                timedOut = 1'b0;
                break;
            end
            @(posedge clk_i);
            #2;
        end
        if (!timedOut) begin
            addr            = mem_req_addr_o;
            mem_req_ready_i = 1'b1;
            @(posedge clk_i);
            #1;
            mem_req_ready_i = 1'b0;
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = data;
            mem_rsp_err_i   = err;
            @(posedge clk_i);
            #1;
            mem_rsp_valid_i = 1'b0;
            mem_rsp_err_i   = 1'b0;
            mem_rsp_data_i  = '0;
            #1;
        end
    endtask

    task automatic test_reset;
        arst_i       = 1'b1;
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #2;
        checks++;
        if ({req0_ready_o, req1_ready_o, mem_req_valid_o, upd_valid_o, done_valid_o} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected 00000",
                     {req0_ready_o, req1_ready_o, mem_req_valid_o, upd_valid_o, done_valid_o});
        end
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        arst_i       = 1'b0;
        idle_cycles(2);
        checks++;
        if ({mem_req_valid_o, mem_req_addr_o, done_valid_o} !== 58'd0) begin
            errors++;
            $display("[TB] FAIL reset_idle: mem_req_valid %b addr %h done %b expected all zero",
                     mem_req_valid_o, mem_req_addr_o, done_valid_o);
        end
    endtask

    task automatic test_round_robin;
        logic [55:0] addr;
        logic        to;
        int          d0;
        // First simultaneous request after reset: ITLB holds priority.
        req0_valid_i = 1'b1;
        req0_vpn_i   = 27'h00C0201;
        req1_valid_i = 1'b1;
        req1_vpn_i   = 27'h0040000;
        #1;
        checks++;
        if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL rr_first_grant: got %b expected 10", {req0_ready_o, req1_ready_o});
        end
        @(posedge clk_i);
        #1;
        req0_valid_i = 1'b0;
        // DTLB keeps asking while the walk is busy: it must not be accepted.
        #1;
        checks++;
        if (req1_ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_outside_idle: got %b expected 0", req1_ready_o);
        end
        req1_valid_i = 1'b0;
        d0 = nDone;
        serve_read((64'h2A << 28) | 64'hCF, 1'b0, addr, to);
        idle_cycles(2);
        checks++;
        if (addr !== 56'h80000018) begin
            errors++;
            $display("[TB] FAIL rr_itlb_addr: got %h expected 80000018 (timeout %b)", addr, to);
        end
        checks++;
        if ({nDone - d0, capId, capFault, capLevel, capPpn2} !== {32'd1, 1'b0, 1'b0, 2'd2, 26'h2A}) begin
            errors++;
            $display("[TB] FAIL rr_itlb_done: dones %0d id %b fault %b level %0d ppn2 %h expected 1 0 0 2 2a",
                     nDone - d0, capId, capFault, capLevel, capPpn2);
        end
        // Second simultaneous request: priority has moved to the DTLB.
        req0_valid_i = 1'b1;
        req0_vpn_i   = 27'h00C0201;
        req1_valid_i = 1'b1;
        req1_vpn_i   = 27'h0040000;
        #1;
        checks++;
        if ({req0_ready_o, req1_ready_o} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rr_second_grant: got %b expected 01", {req0_ready_o, req1_ready_o});
        end
        @(posedge clk_i);
        #1;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        #1;
        d0 = nDone;
        serve_read((64'h2A << 28) | 64'hCF, 1'b0, addr, to);
        idle_cycles(2);
        checks++;
        if (addr !== 56'h80000008) begin
            errors++;
            $display("[TB] FAIL rr_dtlb_addr: got %h expected 80000008 (timeout %b)", addr, to);
        end
        checks++;
        if ({nDone - d0, capId, capSel} !== {32'd1, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL rr_dtlb_done: dones %0d id %b sel %b expected 1 1 1",
                     nDone - d0, capId, capSel);
        end
    endtask

    task automatic test_three_level;
        logic [55:0] addr;
        logic        to;
        logic        rdy;
        int          r0;
        int          u0;
        int          d0;
        r0 = nReads;
        u0 = nUpd;
        d0 = nDone;
        issue_req(1'b1, 27'h0000201, rdy);
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL walk3_ready: got %b expected 1", rdy);
        end
        serve_read((64'h80001 << 10) | 64'h1, 1'b0, addr, to);
        checks++;
        if (addr !== 56'h80000000) begin
            errors++;
            $display("[TB] FAIL walk3_addr_l2: got %h expected 80000000 (timeout %b)", addr, to);
        end
        serve_read((64'h80002 << 10) | 64'h1, 1'b0, addr, to);
        checks++;
        if (addr !== 56'h80001008) begin
            errors++;
            $display("[TB] FAIL walk3_addr_l1: got %h expected 80001008 (timeout %b)", addr, to);
        end
        serve_read((64'h12345 << 28) | (64'h0AB << 19) | (64'h1CD << 10) | 64'hCF, 1'b0, addr, to);
        checks++;
        if (addr !== 56'h80002008) begin
            errors++;
            $display("[TB] FAIL walk3_addr_l0: got %h expected 80002008 (timeout %b)", addr, to);
        end
        idle_cycles(3);
        checks++;
        if ({nReads - r0, nUpd - u0, nDone - d0} !== {32'd3, 32'd1, 32'd1}) begin
            errors++;
            $display("[TB] FAIL walk3_counts: reads %0d upd %0d done %0d expected 3 1 1",
                     nReads - r0, nUpd - u0, nDone - d0);
        end
        checks++;
        if ({capWe, capSel, capLevel, capPte, capVpn} !== {1'b1, 1'b1, 2'd0, 8'hCF, 27'h0000201}) begin
            errors++;
            $display("[TB] FAIL walk3_update: we %b sel %b level %0d pte %h vpn %h expected 1 1 0 cf 0000201",
                     capWe, capSel, capLevel, capPte, capVpn);
        end
        checks++;
        if ({capPpn2, capPpn1, capPpn0} !== {26'h12345, 9'h0AB, 9'h1CD}) begin
            errors++;
            $display("[TB] FAIL walk3_ppn: ppn2 %h ppn1 %h ppn0 %h expected 12345 0ab 1cd",
                     capPpn2, capPpn1, capPpn0);
        end
        checks++;
        if ({capId, capFault, capAccess} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL walk3_done: id %b fault %b access %b expected 1 0 0",
                     capId, capFault, capAccess);
        end
    endtask

    task automatic test_misaligned;
        logic [55:0] addr;
        logic        to;
        logic        rdy;
        int          r0;
        int          u0;
        int          d0;
        // Giga leaf with ppn1 != 0.
        u0 = nUpd;
        d0 = nDone;
        issue_req(1'b0, 27'h0000000, rdy);
        serve_read((64'h3 << 19) | 64'hCF, 1'b0, addr, to);
        idle_cycles(3);
        checks++;
        if ({nUpd - u0, nDone - d0, capFault, capAccess, capId} !== {32'd0, 32'd1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL giga_misaligned: upd %0d done %0d fault %b access %b id %b expected 0 1 1 0 0",
                     nUpd - u0, nDone - d0, capFault, capAccess, capId);
        end
        // Mega leaf with ppn0 != 0.
        r0 = nReads;
        u0 = nUpd;
        d0 = nDone;
        issue_req(1'b0, 27'h0000000, rdy);
        serve_read((64'h80005 << 10) | 64'h1, 1'b0, addr, to);
        serve_read((64'h1 << 10) | 64'hCF, 1'b0, addr, to);
        idle_cycles(3);
        checks++;
        if ({nReads - r0, nUpd - u0, nDone - d0, capFault} !== {32'd2, 32'd0, 32'd1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL mega_misaligned: reads %0d upd %0d done %0d fault %b expected 2 0 1 1",
                     nReads - r0, nUpd - u0, nDone - d0, capFault);
        end
        // Pointer PTE at level 0.
        r0 = nReads;
        u0 = nUpd;
        d0 = nDone;
        issue_req(1'b1, 27'h0000000, rdy);
        serve_read((64'h80005 << 10) | 64'h1, 1'b0, addr, to);
        serve_read((64'h80006 << 10) | 64'h1, 1'b0, addr, to);
        serve_read((64'h80007 << 10) | 64'h1, 1'b0, addr, to);
        idle_cycles(3);
        checks++;
        if ({nReads - r0, nUpd - u0, nDone - d0, capFault, capId} !== {32'd3, 32'd0, 32'd1, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL l0_pointer: reads %0d upd %0d done %0d fault %b id %b expected 3 0 1 1 1",
                     nReads - r0, nUpd - u0, nDone - d0, capFault, capId);
        end
    endtask

    task automatic test_mega_page;
        logic [55:0] addr;
        logic        to;
        logic        rdy;
        int          r0;
        int          u0;
        r0 = nReads;
        u0 = nUpd;
        issue_req(1'b0, 27'h0000600, rdy);
        serve_read((64'h80007 << 10) | 64'h1, 1'b0, addr, to);
        serve_read((64'h55 << 19) | 64'hCF, 1'b0, addr, to);
        checks++;
        if (addr !== 56'h80007018) begin
            errors++;
            $display("[TB] FAIL mega_addr_l1: got %h expected 80007018 (timeout %b)", addr, to);
        end
        idle_cycles(4);
        checks++;
        if ({nReads - r0, nUpd - u0, capLevel, capPpn1, capPpn0, capSel} !==
            {32'd2, 32'd1, 2'd1, 9'h055, 9'h000, 1'b0}) begin
            errors++;
            $display("[TB] FAIL mega_update: reads %0d upd %0d level %0d ppn1 %h ppn0 %h sel %b expected 2 1 1 055 000 0",
                     nReads - r0, nUpd - u0, capLevel, capPpn1, capPpn0, capSel);
        end
    endtask

    task automatic test_flush_wait;
        logic rdy;
        int   r0;
        int   u0;
        int   d0;
        r0 = nReads;
        u0 = nUpd;
        d0 = nDone;
        issue_req(1'b0, 27'h0000000, rdy);
        // Handshake the read, then flush while waiting for the PTE.
        mem_req_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        mem_req_ready_i = 1'b0;
        flush_i         = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i         = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 64'hCF;
        @(posedge clk_i);
        #1;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        req1_valid_i    = 1'b1;
        req1_vpn_i      = 27'h0000000;
        #1;
        checks++;
        if (req1_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_wait_ready: got %b expected 1", req1_ready_o);
        end
        // The new walk is in REQ: flush it before memory accepts.
        @(posedge clk_i);
        #1;
        req1_valid_i = 1'b0;
        flush_i      = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        #1;
        checks++;
        if (mem_req_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_req_drop: mem_req_valid %b expected 0", mem_req_valid_o);
        end
        idle_cycles(3);
        checks++;
        if ({nReads - r0, nUpd - u0, nDone - d0} !== {32'd1, 32'd0, 32'd0}) begin
            errors++;
            $display("[TB] FAIL flush_counts: reads %0d upd %0d done %0d expected 1 0 0",
                     nReads - r0, nUpd - u0, nDone - d0);
        end
    endtask

    task automatic test_access_fault;
        logic [55:0] addr;
        logic        to;
        logic        rdy;
        int          r0;
        int          u0;
        int          d0;
        r0 = nReads;
        u0 = nUpd;
        d0 = nDone;
        issue_req(1'b1, 27'h0000000, rdy);
        serve_read(64'h0, 1'b1, addr, to);
        idle_cycles(3);
        checks++;
        if ({nReads - r0, nUpd - u0, nDone - d0, capFault, capAccess, capId} !==
            {32'd1, 32'd0, 32'd1, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL access_fault: reads %0d upd %0d done %0d fault %b access %b id %b expected 1 0 1 1 1 1",
                     nReads - r0, nUpd - u0, nDone - d0, capFault, capAccess, capId);
        end
        // A stray response while idle must not produce anything.
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 64'hCF;
        @(posedge clk_i);
        #1;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        idle_cycles(3);
        checks++;
        if ({nDone - d0, nUpd - u0, mem_req_valid_o} !== {32'd1, 32'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL late_response: done %0d upd %0d mem_req_valid %b expected 1 0 0",
                     nDone - d0, nUpd - u0, mem_req_valid_o);
        end
    endtask

    initial begin
        arst_i          = 1'b1;
        flush_i         = 1'b0;
        satp_ppn_i      = 44'h80000;
        req0_valid_i    = 1'b0;
        req0_vpn_i      = '0;
        req1_valid_i    = 1'b0;
        req1_vpn_i      = '0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        mem_rsp_err_i   = 1'b0;

        test_reset();
        test_round_robin();
        test_three_level();
        test_misaligned();
        test_mega_page();
        test_flush_wait();
        test_access_fault();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/tlb_refill_ctrl.md
Name: tlb_refill_ctrl

Overview:
Sv39 TLB refill controller for prv664. It arbitrates TLB misses from the ITLB and DTLB requesters and walks the page table through a single-outstanding memory read port. On completion it drives the tlb update port (valid/we/vpn/ppn2/ppn1/ppn0/pte) of the kilo, mega or giga TLB, or reports a page fault to the requester.

Parameters:
PADDR_WIDTH, 56, physical address width of PTE fetches.
RR_INIT, 0, requester holding round-robin priority after reset (0=ITLB, 1=DTLB).

Ports:
clk_i  in  1  clock.
arst_i  in  1  reset, asynchronous, active-high.
flush_i  in  1  sfence/satp change; kills the current walk.
satp_ppn_i  in  44  root page-table PPN.
req0_valid_i / req1_valid_i  in  1  ITLB / DTLB miss request.
req0_vpn_i / req1_vpn_i  in  27  missing VPN {vpn2,vpn1,vpn0}.
req0_ready_o / req1_ready_o  out  1  request accepted this cycle.
mem_req_valid_o  out  1  PTE read request.
mem_req_ready_i  in  1  memory accepts request.
mem_req_addr_o  out  PADDR_WIDTH  PTE address.
mem_rsp_valid_i  in  1  PTE data return.
mem_rsp_data_i  in  64  PTE.
mem_rsp_err_i  in  1  access fault on PTE fetch.
upd_valid_o  out  1  TLB update strobe.
upd_we_o  out  1  TLB write enable (equals upd_valid_o).
upd_sel_o  out  1  target TLB side (0=ITLB, 1=DTLB).
upd_level_o  out  2  0=KILO_PAGE, 1=MEGA_PAGE, 2=GIGA_PAGE TLB.
upd_vpn_o  out  27  walked VPN.
upd_ppn2_o / upd_ppn1_o / upd_ppn0_o  out  26/9/9  PTE PPN fields.
upd_pte_o  out  8  PTE[7:0] (D A G U X W R V).
done_valid_o  out  1  walk finished (one-cycle pulse).
done_id_o  out  1  requester of the finished walk.
done_fault_o  out  1  page fault (1) / success (0).
done_access_fault_o  out  1  mem_rsp_err_i caused the finish.

Behaviour:
- Reset: all outputs 0; FSM=IDLE; rr pointer=RR_INIT; kill flag=0.
- FSM: IDLE -> REQ -> WAIT -> (REQ | UPDATE | FAULT) -> IDLE.
- IDLE: if any reqN_valid_i and no flush_i, grant one requester.
  - Both valid: grant the rr-priority side; rr then points to the other side.
  - reqN_ready_o is high combinationally in that cycle for the granted side only; vpn and id are latched; level=2; ppn=satp_ppn_i.
  - ready is never asserted outside IDLE.
- REQ: mem_req_valid_o=1 with mem_req_addr_o={ppn, vpn[level], 3'b000}, truncated/zero-extended to PADDR_WIDTH. Held stable until mem_req_ready_i, then -> WAIT. The first request appears the cycle after acceptance.
- WAIT: on mem_rsp_valid_i, evaluate the PTE:
  - mem_rsp_err_i -> FAULT with access_fault=1.
  - V=0, or (R=0 & W=1) -> FAULT.
  - Leaf (R|X):
    - level 2 with PTE ppn1|ppn0 != 0 -> FAULT (misaligned superpage).
    - level 1 with ppn0 != 0 -> FAULT (misaligned superpage).
    - otherwise -> UPDATE.
  - Non-leaf: level 0 -> FAULT; else level-=1, ppn=PTE[53:10], -> REQ.
- UPDATE: one cycle with upd_valid_o=upd_we_o=1, fields from the leaf PTE, upd_level_o=level. done_valid_o=1, done_fault_o=0 in the same cycle. -> IDLE.
- FAULT: one cycle with done_valid_o=1, done_fault_o=1, no update. -> IDLE.
- flush_i:
  - In REQ before handshake: drop the request, -> IDLE.
  - In WAIT: set kill; the response is consumed and discarded; no update, no done; -> IDLE.
  - flush_i in UPDATE/FAULT suppresses that cycle's upd_valid_o and done_valid_o.
  - The requester must re-issue.
- Exactly one walk outstanding; a maximum of 3 memory reads per walk.
- Reset mid-walk: immediate return to IDLE and all outputs 0. A late mem_rsp_valid_i seen in IDLE is ignored.

Optional Feature:
Macro PRV664_PTW_AD_CHECK_EN.
- Defined: a leaf with A=0, or DTLB leaf with W=1 & D=0, -> FAULT (software-managed A/D).
- Undefined: A/D bits are passed through unchecked in upd_pte_o.

Test Plan:
1. req1 vpn=0x0000201, satp_ppn=0x80000. L2 PTE non-leaf ppn=0x80001, L1 non-leaf ppn=0x80002, L0 leaf pte=0xCF -> three mem reads at addr 0x80000000, 0x80001008, 0x80002008. Then upd_level=0, upd_pte=0xCF, done_fault=0.
2. req0 and req1 valid together in the same cycle after reset (RR_INIT=0) -> ITLB granted first; on the next simultaneous request the DTLB is granted.
3. L2 leaf pte with ppn1=0x3 -> done_fault=1, upd_valid_o never asserted.
4. L1 leaf aligned (ppn0=0) -> upd_level=1 after exactly 2 reads.
5. flush_i in WAIT, then response arrives -> no upd_valid_o/done_valid_o; FSM in IDLE and ready is high for a pending request the next cycle.
6. mem_rsp_err_i=1 on the first read -> done_fault=1, done_access_fault=1.
